// File: rtl/vc_input_port.sv
// Router input port: per-VC circular flit buffers, XY route computation and
// IDLE/VA/ACTIVE VC state machines that talk to the VC and switch allocators.
module vc_input_port #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int COORD_W     = 2,
  parameter int PAYLOAD_W   = 16,
  parameter int X_CURRENT   = 0,
  parameter int Y_CURRENT   = 0,
  parameter int VC_ID_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int FLIT_W      = 2 + VC_ID_W + PAYLOAD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLIT_W-1:0]         flit_i,
  input  logic                      valid_i,
  output logic                      credit_valid_o,
  output logic [VC_ID_W-1:0]        credit_vc_o,
  output logic [VC_NUM-1:0]         va_request_o,
  output logic [3*VC_NUM-1:0]       out_port_o,
  input  logic [VC_NUM-1:0]         va_grant_i,
  input  logic [VC_ID_W*VC_NUM-1:0] va_vc_i,
  output logic [VC_NUM-1:0]         sa_request_o,
  input  logic [VC_NUM-1:0]         sa_grant_i,
  output logic [FLIT_W-1:0]         flit_o,
  output logic                      flit_valid_o,
  output logic [2:0]                flit_port_o,
  output logic [VC_NUM-1:0]         error_o,
  output logic [2*VC_NUM-1:0]       state_dbg_o
);

  // Handshakes: a request (va/sa) stays high until granted and a grant only
  // acts in a cycle where its own request is high; valid_i has no back-pressure,
  // the upstream is metered by one credit per flit popped.

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(BUFFER_SIZE);
  localparam logic [COORD_W-1:0] X_CUR    = COORD_W'(X_CURRENT);
  localparam logic [COORD_W-1:0] Y_CUR    = COORD_W'(Y_CURRENT);

  localparam logic [1:0] LBL_HEAD     = 2'd0;
  localparam logic [1:0] LBL_BODY     = 2'd1;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_WEST  = 3'd3;
  localparam logic [2:0] PORT_EAST  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VA     = 2'd1,
    ST_ACTIVE = 2'd2
  } vc_state_e;

  logic [FLIT_W-1:0]  r_mem [VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0]   r_wr_ptr [VC_NUM];
  logic [PTR_W-1:0]   r_rd_ptr [VC_NUM];
  logic [CNT_W-1:0]   r_count [VC_NUM];
  vc_state_e          r_state [VC_NUM];
  vc_state_e          w_state_nxt [VC_NUM];
  logic [2:0]         r_out_port [VC_NUM];
  logic [VC_ID_W-1:0] r_va_vc [VC_NUM];
  logic [VC_NUM-1:0]  r_error;
  logic               r_credit_valid;
  logic [VC_ID_W-1:0] r_credit_vc;

  logic [FLIT_W-1:0]  w_head [VC_NUM];
  logic [1:0]         w_label [VC_NUM];
  logic [2:0]         w_route [VC_NUM];
  logic [VC_NUM-1:0]  w_empty;
  logic [VC_NUM-1:0]  w_full;
  logic [VC_NUM-1:0]  w_is_head;
  logic [VC_NUM-1:0]  w_is_last;
  logic [VC_ID_W-1:0] w_wr_vc;
  logic [VC_NUM-1:0]  w_wr;
  logic [VC_NUM-1:0]  w_wr_ok;
  logic [VC_NUM-1:0]  w_pop;
  logic [VC_ID_W-1:0] w_pop_vc;
  logic [VC_NUM-1:0]  w_err_set;

  function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] f);
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;
    x_d = f[COORD_W-1:0];
    y_d = f[2*COORD_W-1:COORD_W];
    if (x_d > X_CUR)      return PORT_EAST;
    else if (x_d < X_CUR) return PORT_WEST;
    else if (y_d > Y_CUR) return PORT_SOUTH;
    else if (y_d < Y_CUR) return PORT_NORTH;
    else                  return PORT_LOCAL;
  endfunction

  // Head-of-line view and write decode
  always_comb begin
    w_wr_vc   = flit_i[PAYLOAD_W +: VC_ID_W];
    w_empty   = '0;
    w_full    = '0;
    w_is_head = '0;
    w_is_last = '0;
    w_wr      = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_head[v]    = r_mem[v][r_rd_ptr[v]];
      w_label[v]   = w_head[v][FLIT_W-1 -: 2];
      w_route[v]   = xy_route(w_head[v]);
      w_empty[v]   = (r_count[v] == '0);
      w_full[v]    = (r_count[v] == FULL_CNT);
      w_is_head[v] = (w_label[v] == LBL_HEAD) || (w_label[v] == LBL_HEADTAIL);
      w_is_last[v] = (w_label[v] == LBL_TAIL) || (w_label[v] == LBL_HEADTAIL);
      w_wr[v]      = valid_i && (w_wr_vc == VC_ID_W'(v));
    end
  end

  // A full buffer still accepts a write when the same VC pops this cycle.
  always_comb begin
    w_wr_ok = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_wr_ok[v] = w_wr[v] && (!w_full[v] || w_pop[v]);
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_wr_ok[v]) r_mem[v][r_wr_ptr[v]] <= flit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_wr_ok[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        if (w_pop[v])   r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
        case ({w_wr_ok[v], w_pop[v]})
          2'b10:   r_count[v] <= r_count[v] + CNT_W'(1);
          2'b01:   r_count[v] <= r_count[v] - CNT_W'(1);
          default: r_count[v] <= r_count[v];
        endcase
      end
    end
  end

  // VC FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) r_state[v] <= ST_IDLE;
    end else begin
      for (int v = 0; v < VC_NUM; v++) r_state[v] <= w_state_nxt[v];
    end
  end

  // VC FSM: next state; a non-head flit at the front of an idle VC is a protocol error
  always_comb begin
    w_err_set = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_state_nxt[v] = r_state[v];
      w_err_set[v]   = w_wr[v] && w_full[v] && !w_pop[v];
      case (r_state[v])
        ST_IDLE: begin
          if (!w_empty[v]) begin
            if (w_is_head[v]) w_state_nxt[v] = ST_VA;
            else              w_err_set[v]   = 1'b1;
          end
        end
        ST_VA:     if (va_grant_i[v]) w_state_nxt[v] = ST_ACTIVE;
        ST_ACTIVE: if (w_pop[v] && w_is_last[v]) w_state_nxt[v] = ST_IDLE;
        default:   w_state_nxt[v] = ST_IDLE;
      endcase
    end
  end

  // VC FSM: outputs and crossbar drive
  always_comb begin
    va_request_o = '0;
    sa_request_o = '0;
    w_pop        = '0;
    w_pop_vc     = '0;
    flit_o       = '0;
    flit_valid_o = 1'b0;
    flit_port_o  = PORT_LOCAL;
    for (int v = 0; v < VC_NUM; v++) begin
      va_request_o[v] = (r_state[v] == ST_VA);
      sa_request_o[v] = (r_state[v] == ST_ACTIVE) && !w_empty[v];
      w_pop[v]        = sa_request_o[v] && sa_grant_i[v];
      if (w_pop[v]) begin
        flit_valid_o = 1'b1;
        flit_o       = {w_label[v], r_va_vc[v], w_head[v][PAYLOAD_W-1:0]};
        flit_port_o  = r_out_port[v];
        w_pop_vc     = VC_ID_W'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error        <= '0;
      r_credit_valid <= 1'b0;
      r_credit_vc    <= '0;
      for (int v = 0; v < VC_NUM; v++) begin
        r_out_port[v] <= PORT_LOCAL;
        r_va_vc[v]    <= '0;
      end
    end else begin
      r_error        <= r_error | w_err_set;
      r_credit_valid <= |w_pop;
      r_credit_vc    <= w_pop_vc;
      for (int v = 0; v < VC_NUM; v++) begin
        if (r_state[v] == ST_IDLE && w_state_nxt[v] == ST_VA) r_out_port[v] <= w_route[v];
        if (r_state[v] == ST_VA && va_grant_i[v]) r_va_vc[v] <= va_vc_i[VC_ID_W*v +: VC_ID_W];
      end
    end
  end

  always_comb begin
    out_port_o  = '0;
    state_dbg_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      out_port_o[3*v +: 3]  = r_out_port[v];
      state_dbg_o[2*v +: 2] = r_state[v];
    end
  end

  assign error_o        = r_error;
  assign credit_valid_o = r_credit_valid;
  assign credit_vc_o    = r_credit_vc;

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port on a router at (1,1) with two VCs of eight flits.
module tb_vc_input_port;

  localparam int VC_NUM    = 2;
  localparam int VC_ID_W   = 1;
  localparam int PAYLOAD_W = 16;
  localparam int FLIT_W    = 2 + VC_ID_W + PAYLOAD_W;

  localparam logic [1:0] L_HEAD = 2'd0;
  localparam logic [1:0] L_BODY = 2'd1;
  localparam logic [1:0] L_TAIL = 2'd2;
  localparam logic [1:0] L_HT   = 2'd3;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [FLIT_W-1:0]         flit_i = '0;
  logic                      valid_i = 1'b0;
  logic                      credit_valid_o;
  logic [VC_ID_W-1:0]        credit_vc_o;
  logic [VC_NUM-1:0]         va_request_o;
  logic [3*VC_NUM-1:0]       out_port_o;
  logic [VC_NUM-1:0]         va_grant_i = '0;
  logic [VC_ID_W*VC_NUM-1:0] va_vc_i = '0;
  logic [VC_NUM-1:0]         sa_request_o;
  logic [VC_NUM-1:0]         sa_grant_i = '0;
  logic [FLIT_W-1:0]         flit_o;
  logic                      flit_valid_o;
  logic [2:0]                flit_port_o;
  logic [VC_NUM-1:0]         error_o;
  logic [2*VC_NUM-1:0]       state_dbg_o;

  int total = 0;
  int bad   = 0;

  vc_input_port #(
    .VC_NUM(VC_NUM), .BUFFER_SIZE(8), .COORD_W(2), .PAYLOAD_W(PAYLOAD_W),
    .X_CURRENT(1), .Y_CURRENT(1)
  ) dut (
    .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i),
    .credit_valid_o(credit_valid_o), .credit_vc_o(credit_vc_o),
    .va_request_o(va_request_o), .out_port_o(out_port_o),
    .va_grant_i(va_grant_i), .va_vc_i(va_vc_i),
    .sa_request_o(sa_request_o), .sa_grant_i(sa_grant_i),
    .flit_o(flit_o), .flit_valid_o(flit_valid_o), .flit_port_o(flit_port_o),
    .error_o(error_o), .state_dbg_o(state_dbg_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (rst || $onehot0(sa_grant_i)) else $error("illegal stimulus: sa_grant_i=%b", sa_grant_i);
  end

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] lbl, input logic vc,
                                                input logic [15:0] pl);
    return {lbl, vc, pl};
  endfunction

  // Step to 1 time unit past the next rising edge with all pulse inputs idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    valid_i    = 1'b0;
    flit_i     = '0;
    va_grant_i = '0;
    va_vc_i    = '0;
    sa_grant_i = '0;
  endtask

  task automatic test_reset();
    next_cycle();
    #4;
    total++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin bad++;
      $display("FAIL rst_req va=%b sa=%b exp 00/00", va_request_o, sa_request_o); end
    total++; if (out_port_o !== 6'd0 || error_o !== 2'b00) begin bad++;
      $display("FAIL rst_port_err port=%h err=%b exp 0/00", out_port_o, error_o); end
    total++; if (flit_valid_o !== 1'b0 || flit_o !== '0 || flit_port_o !== 3'd0) begin bad++;
      $display("FAIL rst_flit v=%b f=%h p=%0d exp 0/0/0", flit_valid_o, flit_o, flit_port_o); end
    total++; if (credit_valid_o !== 1'b0 || credit_vc_o !== 1'b0 || state_dbg_o !== 4'd0) begin bad++;
      $display("FAIL rst_credit_state cv=%b cvc=%b st=%h exp 0/0/0", credit_valid_o, credit_vc_o, state_dbg_o); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_headtail();
    next_cycle();
    valid_i = 1'b1; flit_i = mk_flit(L_HT, 1'b0, 16'h5A03);
    next_cycle();
    #4;
    total++; if (va_request_o !== 2'b00) begin bad++;
      $display("FAIL ht_idle_va got=%b exp=00", va_request_o); end
    next_cycle();
    va_grant_i = 2'b01; va_vc_i = 2'b01; sa_grant_i = 2'b01;
    #4;
    total++; if (va_request_o !== 2'b01 || out_port_o[2:0] !== 3'd4) begin bad++;
      $display("FAIL ht_va va=%b port=%0d exp 01/4", va_request_o, out_port_o[2:0]); end
    total++; if (flit_valid_o !== 1'b0) begin bad++;
      $display("FAIL ht_ignored_sa got=%b exp=0", flit_valid_o); end
    next_cycle();
    sa_grant_i = 2'b01;
    #4;
    total++; if (sa_request_o !== 2'b01 || flit_valid_o !== 1'b1) begin bad++;
      $display("FAIL ht_sa sa=%b fv=%b exp 01/1", sa_request_o, flit_valid_o); end
    total++; if (flit_o !== mk_flit(L_HT, 1'b1, 16'h5A03) || flit_port_o !== 3'd4) begin bad++;
      $display("FAIL ht_flit got=%h/%0d exp=%h/4", flit_o, flit_port_o, mk_flit(L_HT, 1'b1, 16'h5A03)); end
    next_cycle();
    #4;
    total++; if (credit_valid_o !== 1'b1 || credit_vc_o !== 1'b0) begin bad++;
      $display("FAIL ht_credit cv=%b vc=%b exp 1/0", credit_valid_o, credit_vc_o); end
    total++; if (state_dbg_o[1:0] !== 2'd0 || sa_request_o !== 2'b00) begin bad++;
      $display("FAIL ht_back_idle st=%0d sa=%b exp 0/00", state_dbg_o[1:0], sa_request_o); end
    next_cycle();
    #4;
    total++; if (credit_valid_o !== 1'b0) begin bad++;
      $display("FAIL ht_credit_pulse got=%b exp=0", credit_valid_o); end
  endtask

  task automatic test_packet();
    logic [1:0]  lbl [4];
    logic [15:0] pl  [4];
    lbl = '{L_HEAD, L_BODY, L_BODY, L_TAIL};
    pl  = '{16'h1005, 16'h2222, 16'h3333, 16'h4444};
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(lbl[0], 1'b1, pl[0]);
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(lbl[1], 1'b1, pl[1]);
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(lbl[2], 1'b1, pl[2]);
    va_grant_i = 2'b10; va_vc_i = 2'b00;
    #4;
    total++; if (va_request_o !== 2'b10 || out_port_o[5:3] !== 3'd0) begin bad++;
      $display("FAIL pkt_va va=%b port=%0d exp 10/0", va_request_o, out_port_o[5:3]); end
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(lbl[3], 1'b1, pl[3]);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      sa_grant_i = 2'b10;
      #4;
      total++; if (flit_valid_o !== 1'b1 || flit_o !== mk_flit(lbl[k], 1'b0, pl[k]) || flit_port_o !== 3'd0) begin bad++;
        $display("FAIL pkt_flit%0d got=%b/%h/%0d exp=1/%h/0", k, flit_valid_o, flit_o, flit_port_o, mk_flit(lbl[k], 1'b0, pl[k])); end
      if (k > 0) begin
        total++; if (credit_valid_o !== 1'b1 || credit_vc_o !== 1'b1 || state_dbg_o[3:2] !== 2'd2) begin bad++;
          $display("FAIL pkt_mid%0d cv=%b vc=%b st=%0d exp 1/1/2", k, credit_valid_o, credit_vc_o, state_dbg_o[3:2]); end
      end
    end
    next_cycle();
    #4;
    total++; if (credit_valid_o !== 1'b1 || credit_vc_o !== 1'b1 || state_dbg_o !== 4'd0 || sa_request_o !== 2'b00) begin bad++;
      $display("FAIL pkt_end cv=%b vc=%b st=%h sa=%b exp 1/1/0/00", credit_valid_o, credit_vc_o, state_dbg_o, sa_request_o); end
  endtask

  task automatic test_interleave();
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_HEAD, 1'b0, 16'h0A04);
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_HT, 1'b1, 16'h0B01);
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_BODY, 1'b0, 16'hCAFE);
    va_grant_i = 2'b01; va_vc_i = 2'b01;
    #4;
    total++; if (va_request_o !== 2'b01 || out_port_o[2:0] !== 3'd3) begin bad++;
      $display("FAIL il_va0 va=%b port=%0d exp 01/3", va_request_o, out_port_o[2:0]); end
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_TAIL, 1'b0, 16'hBEEF);
    va_grant_i = 2'b10; va_vc_i = 2'b01; sa_grant_i = 2'b01;
    #4;
    total++; if (va_request_o !== 2'b10 || out_port_o[5:3] !== 3'd1 || sa_request_o !== 2'b01) begin bad++;
      $display("FAIL il_va1 va=%b port=%0d sa=%b exp 10/1/01", va_request_o, out_port_o[5:3], sa_request_o); end
    total++; if (flit_o !== mk_flit(L_HEAD, 1'b1, 16'h0A04) || flit_port_o !== 3'd3) begin bad++;
      $display("FAIL il_vc0_head got=%h/%0d exp=%h/3", flit_o, flit_port_o, mk_flit(L_HEAD, 1'b1, 16'h0A04)); end
    next_cycle(); sa_grant_i = 2'b10;
    #4;
    total++; if (sa_request_o !== 2'b11 || credit_valid_o !== 1'b1 || credit_vc_o !== 1'b0) begin bad++;
      $display("FAIL il_both sa=%b cv=%b vc=%b exp 11/1/0", sa_request_o, credit_valid_o, credit_vc_o); end
    total++; if (flit_o !== mk_flit(L_HT, 1'b0, 16'h0B01) || flit_port_o !== 3'd1) begin bad++;
      $display("FAIL il_vc1_flit got=%h/%0d exp=%h/1", flit_o, flit_port_o, mk_flit(L_HT, 1'b0, 16'h0B01)); end
    next_cycle(); sa_grant_i = 2'b01;
    #4;
    total++; if (flit_o !== mk_flit(L_BODY, 1'b1, 16'hCAFE) || credit_vc_o !== 1'b1 || state_dbg_o[3:2] !== 2'd0) begin bad++;
      $display("FAIL il_vc0_body got=%h cvc=%b st1=%0d exp=%h/1/0", flit_o, credit_vc_o, state_dbg_o[3:2], mk_flit(L_BODY, 1'b1, 16'hCAFE)); end
    next_cycle(); sa_grant_i = 2'b01;
    #4;
    total++; if (flit_o !== mk_flit(L_TAIL, 1'b1, 16'hBEEF) || flit_port_o !== 3'd3) begin bad++;
      $display("FAIL il_vc0_tail got=%h/%0d exp=%h/3", flit_o, flit_port_o, mk_flit(L_TAIL, 1'b1, 16'hBEEF)); end
    next_cycle();
    #4;
    total++; if (state_dbg_o !== 4'd0 || error_o !== 2'b00 || credit_vc_o !== 1'b0) begin bad++;
      $display("FAIL il_end st=%h err=%b cvc=%b exp 0/00/0", state_dbg_o, error_o, credit_vc_o); end
  endtask

  task automatic test_body_first();
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_BODY, 1'b1, 16'h7777);
    next_cycle();
    next_cycle();
    #4;
    total++; if (error_o !== 2'b10 || va_request_o !== 2'b00) begin bad++;
      $display("FAIL bf_err err=%b va=%b exp 10/00", error_o, va_request_o); end
    next_cycle();
    #4;
    total++; if (error_o !== 2'b10 || va_request_o !== 2'b00 || state_dbg_o !== 4'd0) begin bad++;
      $display("FAIL bf_hold err=%b va=%b st=%h exp 10/00/0", error_o, va_request_o, state_dbg_o); end
    next_cycle(); rst = 1'b1;
    next_cycle();
    #4;
    total++; if (error_o !== 2'b00 || va_request_o !== 2'b00 || sa_request_o !== 2'b00 ||
                 out_port_o !== 6'd0 || credit_valid_o !== 1'b0 || flit_valid_o !== 1'b0) begin bad++;
      $display("FAIL bf_rst err=%b va=%b sa=%b port=%h cv=%b fv=%b exp all 0", error_o, va_request_o,
               sa_request_o, out_port_o, credit_valid_o, flit_valid_o); end
    next_cycle(); rst = 1'b0;
    next_cycle();
    next_cycle();
    #4;
    total++; if (error_o !== 2'b00 || va_request_o !== 2'b00) begin bad++;
      $display("FAIL bf_flushed err=%b va=%b exp 00/00", error_o, va_request_o); end
  endtask

  task automatic test_full_drop();
    logic [1:0] lbl;
    for (int k = 0; k < 8; k++) begin
      next_cycle(); valid_i = 1'b1;
      flit_i = mk_flit((k == 0) ? L_HEAD : ((k == 7) ? L_TAIL : L_BODY), 1'b0, 16'h0100 + 16'(k));
    end
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_HT, 1'b0, 16'hDEAD);
    #4;
    total++; if (error_o !== 2'b00) begin bad++;
      $display("FAIL fd_pre_err got=%b exp=00", error_o); end
    next_cycle(); va_grant_i = 2'b01; va_vc_i = 2'b00;
    #4;
    total++; if (error_o !== 2'b01 || va_request_o !== 2'b01 || out_port_o[2:0] !== 3'd3) begin bad++;
      $display("FAIL fd_err err=%b va=%b port=%0d exp 01/01/3", error_o, va_request_o, out_port_o[2:0]); end
    for (int k = 0; k < 8; k++) begin
      next_cycle(); sa_grant_i = 2'b01;
      lbl = (k == 0) ? L_HEAD : ((k == 7) ? L_TAIL : L_BODY);
      #4;
      total++; if (flit_valid_o !== 1'b1 || flit_o !== mk_flit(lbl, 1'b0, 16'h0100 + 16'(k))) begin bad++;
        $display("FAIL fd_drain%0d got=%b/%h exp=1/%h", k, flit_valid_o, flit_o, mk_flit(lbl, 1'b0, 16'h0100 + 16'(k))); end
    end
    next_cycle();
    #4;
    total++; if (sa_request_o !== 2'b00 || state_dbg_o[1:0] !== 2'd0) begin bad++;
      $display("FAIL fd_idle sa=%b st=%0d exp 00/0", sa_request_o, state_dbg_o[1:0]); end
    next_cycle();
    #4;
    total++; if (va_request_o !== 2'b00) begin bad++;
      $display("FAIL fd_dropped va=%b exp=00", va_request_o); end
    next_cycle(); rst = 1'b1;
    next_cycle();
    next_cycle(); rst = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [1:0] lbl;
    for (int k = 0; k < 8; k++) begin
      next_cycle(); valid_i = 1'b1;
      flit_i = mk_flit((k == 0) ? L_HEAD : L_BODY, 1'b0, 16'h0200 + 16'(k));
    end
    next_cycle(); va_grant_i = 2'b01; va_vc_i = 2'b01;
    #4;
    total++; if (va_request_o !== 2'b01 || error_o !== 2'b00) begin bad++;
      $display("FAIL fp_va va=%b err=%b exp 01/00", va_request_o, error_o); end
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_TAIL, 1'b0, 16'h0208); sa_grant_i = 2'b01;
    #4;
    total++; if (flit_valid_o !== 1'b1 || flit_o !== mk_flit(L_HEAD, 1'b1, 16'h0200)) begin bad++;
      $display("FAIL fp_pop0 got=%b/%h exp=1/%h", flit_valid_o, flit_o, mk_flit(L_HEAD, 1'b1, 16'h0200)); end
    for (int k = 1; k < 9; k++) begin
      next_cycle(); sa_grant_i = 2'b01;
      lbl = (k == 8) ? L_TAIL : L_BODY;
      #4;
      total++; if (flit_valid_o !== 1'b1 || flit_o !== mk_flit(lbl, 1'b1, 16'h0200 + 16'(k)) || error_o !== 2'b00) begin bad++;
        $display("FAIL fp_drain%0d got=%b/%h err=%b exp=1/%h/00", k, flit_valid_o, flit_o, error_o, mk_flit(lbl, 1'b1, 16'h0200 + 16'(k))); end
    end
    next_cycle();
    #4;
    total++; if (sa_request_o !== 2'b00 || state_dbg_o[1:0] !== 2'd0 || error_o !== 2'b00) begin bad++;
      $display("FAIL fp_end sa=%b st=%0d err=%b exp 00/0/00", sa_request_o, state_dbg_o[1:0], error_o); end
  endtask

  task automatic test_back_to_back();
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_HEAD, 1'b0, 16'hA007);
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_TAIL, 1'b0, 16'hA0FF);
    next_cycle(); valid_i = 1'b1; flit_i = mk_flit(L_HT, 1'b0, 16'hB00D);
    va_grant_i = 2'b01; va_vc_i = 2'b01;
    #4;
    total++; if (va_request_o !== 2'b01 || out_port_o[2:0] !== 3'd4) begin bad++;
      $display("FAIL b2b_va_a va=%b port=%0d exp 01/4", va_request_o, out_port_o[2:0]); end
    next_cycle(); sa_grant_i = 2'b01;
    #4;
    total++; if (flit_o !== mk_flit(L_HEAD, 1'b1, 16'hA007) || flit_port_o !== 3'd4) begin bad++;
      $display("FAIL b2b_a_head got=%h/%0d exp=%h/4", flit_o, flit_port_o, mk_flit(L_HEAD, 1'b1, 16'hA007)); end
    next_cycle(); sa_grant_i = 2'b01;
    #4;
    total++; if (flit_o !== mk_flit(L_TAIL, 1'b1, 16'hA0FF) || flit_port_o !== 3'd4) begin bad++;
      $display("FAIL b2b_a_tail got=%h/%0d exp=%h/4", flit_o, flit_port_o, mk_flit(L_TAIL, 1'b1, 16'hA0FF)); end
    next_cycle();
    #4;
    total++; if (state_dbg_o[1:0] !== 2'd0 || va_request_o !== 2'b00 || credit_valid_o !== 1'b1) begin bad++;
      $display("FAIL b2b_gap st=%0d va=%b cv=%b exp 0/00/1", state_dbg_o[1:0], va_request_o, credit_valid_o); end
    next_cycle(); va_grant_i = 2'b01; va_vc_i = 2'b00;
    #4;
    total++; if (va_request_o !== 2'b01 || out_port_o[2:0] !== 3'd2) begin bad++;
      $display("FAIL b2b_va_b va=%b port=%0d exp 01/2", va_request_o, out_port_o[2:0]); end
    next_cycle(); sa_grant_i = 2'b01;
    #4;
    total++; if (flit_valid_o !== 1'b1 || flit_o !== mk_flit(L_HT, 1'b0, 16'hB00D) || flit_port_o !== 3'd2) begin bad++;
      $display("FAIL b2b_b got=%b/%h/%0d exp=1/%h/2", flit_valid_o, flit_o, flit_port_o, mk_flit(L_HT, 1'b0, 16'hB00D)); end
    next_cycle();
    #4;
    total++; if (state_dbg_o !== 4'd0 || sa_request_o !== 2'b00 || credit_valid_o !== 1'b1 || error_o !== 2'b00) begin bad++;
      $display("FAIL b2b_end st=%h sa=%b cv=%b err=%b exp 0/00/1/00", state_dbg_o, sa_request_o, credit_valid_o, error_o); end
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_packet();
    test_interleave();
    test_body_first();
    test_full_drop();
    test_full_pop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_input_port.md
Name: vc_input_port

Overview:
Parametrised router input port with VC_NUM virtual channels. Each VC has its own circular flit buffer, XY route computation and VC state machine (IDLE/VA/ACTIVE). The port exchanges requests and grants with the VC allocator and switch allocator, drives the granted flit to the crossbar, and returns one credit per flit read out.

Parameters:
VC_NUM, 2, number of virtual channels (>=1); VC_ID_W = max(1, clog2(VC_NUM)).
BUFFER_SIZE, 8, flits per VC buffer (power of two, >=2).
COORD_W, 2, width of each mesh coordinate.
PAYLOAD_W, 16, flit payload width (>= 2*COORD_W); FLIT_W = 2 + VC_ID_W + PAYLOAD_W.
X_CURRENT, 0, this router's x coordinate.
Y_CURRENT, 0, this router's y coordinate.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flit_i  in  FLIT_W  {label[1:0], vc_id, payload}; label HEAD=0, BODY=1, TAIL=2, HEADTAIL=3; head payload[COORD_W-1:0]=x_dest, next COORD_W bits=y_dest
valid_i  in  1  flit_i valid this cycle
credit_valid_o  out  1  one-cycle credit pulse to upstream
credit_vc_o  out  VC_ID_W  VC the credit belongs to
va_request_o  out  VC_NUM  per-VC VC-allocation request
out_port_o  out  3*VC_NUM  per-VC latched route: LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4
va_grant_i  in  VC_NUM  per-VC VC-allocation grant
va_vc_i  in  VC_ID_W*VC_NUM  per-VC granted downstream VC
sa_request_o  out  VC_NUM  per-VC switch request
sa_grant_i  in  VC_NUM  switch grant, at most one bit set
flit_o  out  FLIT_W  flit to crossbar, vc_id field replaced by the downstream VC
flit_valid_o  out  1  flit_o valid
flit_port_o  out  3  route of flit_o
error_o  out  VC_NUM  sticky per-VC protocol-error flag

Behaviour:
- Reset: all buffers empty, all VCs IDLE, every output 0. Reset mid-packet discards all buffered flits and clears error_o.
- Write: valid_i stores flit_i in buffer[flit_i.vc_id] at the clock edge. A write to a full buffer with no same-cycle read from that VC drops the flit and sets error_o[vc]. Full with a same-cycle read: the write is accepted and the count stays BUFFER_SIZE. Pointers wrap modulo BUFFER_SIZE.
- RC (combinational on the VC's head-of-line flit):
  - x_dest > X_CURRENT -> EAST; x_dest < X_CURRENT -> WEST.
  - Otherwise y_dest > Y_CURRENT -> SOUTH; y_dest < Y_CURRENT -> NORTH.
  - Otherwise LOCAL.
- Per-VC FSM:
  - IDLE: if the buffer is non-empty and the head-of-line label is HEAD or HEADTAIL, latch the route into out_port_o and go to VA. If the head-of-line flit is BODY or TAIL, set error_o, stay IDLE and hold the flit.
  - VA: va_request_o=1. On va_grant_i, latch va_vc_i and go to ACTIVE. va_grant_i in any other state is ignored.
  - ACTIVE: sa_request_o = buffer non-empty. On sa_grant_i[vc] with a request present, pop the head-of-line flit in the same cycle:
    - flit_valid_o=1, flit_o = head-of-line flit with vc_id replaced by the latched downstream VC, flit_port_o = latched route.
    - If the popped flit is TAIL or HEADTAIL, go to IDLE. The next head is considered from the following cycle.
  - A grant to a non-requesting VC is ignored: no pop, flit_valid_o=0.
- Credit: registered. credit_valid_o=1 with credit_vc_o=vc the cycle after each pop.
- Latency: head written at cycle t -> IDLE->VA at t+1 -> earliest ACTIVE at t+2 (grant at t+1) -> earliest output at t+2.
- Simultaneous read and write on the same VC is legal.
- Multiple sa_grant_i bits set is illegal stimulus (bench assertion).

Test Plan:
- X_CURRENT=Y_CURRENT=1; HEADTAIL on VC0, dest (3,0) -> out_port_o[0]=EAST, va_request_o[0] at t+1. Grant va_vc=1 at t+1, sa_grant at t+2 -> flit_o vc_id=1, flit_port_o=4. Credit for VC0 at t+3; VC0 back in IDLE.
- 4-flit packet (HEAD, BODY, BODY, TAIL), dest (1,1), on VC1 -> route LOCAL. Four sa grants give four outputs in order and four credits. The VC returns to IDLE only after the TAIL pops.
- Interleave writes to VC0 and VC1 while VC0 is ACTIVE -> independent FSMs; flits never cross VCs.
- Fill VC0 with 8 flits, then write a 9th with no grant -> flit dropped, error_o[0]=1. Repeat with a same-cycle pop -> accepted, no error.
- BODY as the first flit into an empty VC -> error_o=1, no va_request. Assert rst -> error_o=0, buffers empty, all outputs 0.
- Back-to-back packets on VC0 (TAIL then HEAD queued) -> IDLE for one cycle, then VA with the new route; no flit is lost; write/read pointers wrap correctly across more than 8 flits.
